lcd_capture_if: RTL and testbench
=================================

LCD_CAPTURE_IF -- requirements
Module: lcd_capture_if

Interface
REQ-001 SHALL have parameter W_ADDR, default 32, AHB address width.
REQ-002 SHALL have parameter W_DATA, default 32, AHB data width.
REQ-003 SHALL have parameter W_WB_DATA, default 2, byte-offset bits dropped from sl_HADDR.
REQ-004 SHALL have parameter IMG_PIX_W, default 8, per-channel pixel width.
REQ-005 SHALL have parameter W_SIZE, default 12, width/height/row/col register width.
REQ-006 SHALL have ports: HCLK in 1, sole clock; HRESET in 1, reset, synchronous, active-high.
REQ-007 SHALL have AHB slave inputs: sl_HREADY 1, sl_HSEL 1, sl_HTRANS 2, sl_HBURST 3, sl_HSIZE 3, sl_HADDR W_ADDR, sl_HWRITE 1, sl_HWDATA W_DATA.
REQ-008 SHALL have AHB slave outputs: out_sl_HREADY 1, out_sl_HRESP 2, out_sl_HRDATA W_DATA.
REQ-009 SHALL have pixel inputs: in_valid 1, two-pixel beat qualifier; in_r0, in_g0, in_b0, in_r1, in_g1, in_b1, each IMG_PIX_W, pixels col and col+1.
REQ-010 SHALL have output out_irq 1, frame-done interrupt.

Function
REQ-011 SHALL latch register select sl_HADDR[W_WB_DATA+3:W_WB_DATA] and write-enable in the address phase when sl_HSEL & sl_HREADY & HTRANS is NONSEQ or SEQ; write-enable otherwise clears.
REQ-012 SHALL apply sl_HWDATA in the cycle after the address phase (data phase); out_sl_HREADY constant 1, out_sl_HRESP constant OKAY.
REQ-013 SHALL drive out_sl_HRDATA combinationally from the latched select, zero-extended; unmapped offsets read 0.
REQ-014 Register map (word offset): 0 WIDTH rw reset 768; 1 HEIGHT rw reset 512; 2 CTRL rw bit0 enable, bit1 irq_en, reset 0; 3 STATUS bit0 busy ro, bit1 done W1C, bit2 overrun W1C; 4 FRAME_CNT ro 32b; 5 SUM_R, 6 SUM_G, 7 SUM_B ro 32b; 8 ROW ro live row.
REQ-015 Writes to WIDTH/HEIGHT SHALL be ignored unless FSM is IDLE.
REQ-016 FSM states: IDLE, WAIT, CAPT.
REQ-017 IDLE -> WAIT when enable=1; WAIT -> CAPT on in_valid=1 (beat consumed that cycle); any state -> IDLE when enable=0, discarding accumulators, row, col.
REQ-018 Each in_valid beat in WAIT/CAPT: col += 2; acc_r += in_r0+in_r1, likewise G, B, modulo 2^32.
REQ-019 When col == WIDTH-2 on a beat: col <= 0, row += 1; in_valid low between beats/lines SHALL NOT affect counts.
REQ-020 Frame ends on the beat with col == WIDTH-2 and row == HEIGHT-1: next cycle SUM_* = final accumulator (incl. that beat), FRAME_CNT += 1 (wraps), done = 1, row/col/acc cleared, FSM -> WAIT.
REQ-021 If done is already 1 at frame end, overrun SHALL be set; results still overwritten.
REQ-022 W1C write clearing done/overrun in the same cycle as a set SHALL leave the bit set.
REQ-023 busy = 1 in CAPT only; out_irq = irq_en & done, registered-state derived, no combinational path from bus inputs.
REQ-024 WIDTH odd or 0, HEIGHT 0: behaviour undefined, need not be checked.

Reset
REQ-025 On HRESET=1 at a HCLK edge: FSM IDLE, row/col/acc 0, SUM_* 0, FRAME_CNT 0, STATUS 0, CTRL 0, WIDTH 768, HEIGHT 512, latched select 0, write-enable 0; out_irq 0, out_sl_HRDATA = 768 (select 0).
REQ-026 Reset mid-frame SHALL discard the partial frame; no SUM_*/FRAME_CNT update.

Verification
REQ-027 Reset, read offsets 0..8 -> 768, 512, 0, 0, 0, 0, 0, 0, 0.
REQ-028 WIDTH=4, HEIGHT=2, CTRL=3, send 4 beats all pixels r=1 g=2 b=3 with gaps -> SUM_R=8, SUM_G=16, SUM_B=24, FRAME_CNT=1, done=1, out_irq=1.
REQ-029 Repeat 2nd identical frame without clearing done -> FRAME_CNT=2, overrun=1; write STATUS=6 -> STATUS=0, out_irq=0.
REQ-030 Clear CTRL.enable after 3 of 4 beats, re-enable, send 4 beats r=255 -> SUM_R=2040, FRAME_CNT increments by exactly 1.
REQ-031 Write WIDTH=8 while CAPT -> WIDTH reads 4; after enable=0 write WIDTH=8 -> reads 8.
REQ-032 Assert HRESET during beat 2 of a frame -> all registers at REQ-025 values next cycle.

Source files
------------

// File: rtl/lcd_capture_if.sv
// Two-pixel-per-beat LCD frame capture with AHB-lite register access.
// Accumulates per-channel pixel sums over a WIDTH x HEIGHT frame and flags completion.
module lcd_capture_if #(
   parameter int W_ADDR    = 32,
   parameter int W_DATA    = 32,
   parameter int W_WB_DATA = 2,
   parameter int IMG_PIX_W = 8,
   parameter int W_SIZE    = 12
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic                 sl_HREADY,
   input  logic                 sl_HSEL,
   input  logic [1:0]           sl_HTRANS,
   input  logic [2:0]           sl_HBURST,
   input  logic [2:0]           sl_HSIZE,
   input  logic [W_ADDR-1:0]    sl_HADDR,
   input  logic                 sl_HWRITE,
   input  logic [W_DATA-1:0]    sl_HWDATA,
   output logic                 out_sl_HREADY,
   output logic [1:0]           out_sl_HRESP,
   output logic [W_DATA-1:0]    out_sl_HRDATA,
   input  logic                 in_valid,
   input  logic [IMG_PIX_W-1:0] in_r0,
   input  logic [IMG_PIX_W-1:0] in_g0,
   input  logic [IMG_PIX_W-1:0] in_b0,
   input  logic [IMG_PIX_W-1:0] in_r1,
   input  logic [IMG_PIX_W-1:0] in_g1,
   input  logic [IMG_PIX_W-1:0] in_b1,
   output logic                 out_irq
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_CAPT = 2'd2
   } state_t;

   state_t             state_r, state_n;
   logic [3:0]         sel_r;
   logic               we_r;
   logic [W_SIZE-1:0]  width_r, height_r, row_r, col_r;
   logic               en_r, irq_en_r, done_r, overrun_r;
   logic [31:0]        frame_cnt_r, sum_red_r, sum_grn_r, sum_blu_r;
   logic [31:0]        acc_red_r, acc_grn_r, acc_blu_r;
   logic [31:0]        add_red_s, add_grn_s, add_blu_s, rd_s;
   logic               beat_s, line_end_s, frame_end_s, addr_ok_s;
   logic               wr_s, w1c_done_s, w1c_ovr_s;
   logic               unused_ok_s;

   assign out_sl_HREADY = 1'b1;
   assign out_sl_HRESP  = 2'b00;
   assign out_irq       = irq_en_r & done_r;

   assign addr_ok_s   = sl_HSEL & sl_HREADY & sl_HTRANS[1];
   assign wr_s        = we_r;
   assign w1c_done_s  = wr_s & (sel_r == 4'd3) & sl_HWDATA[1];
   assign w1c_ovr_s   = wr_s & (sel_r == 4'd3) & sl_HWDATA[2];
   assign beat_s      = in_valid & en_r & (state_r != ST_IDLE);
   assign line_end_s  = (col_r == (width_r - W_SIZE'(2)));
   assign frame_end_s = beat_s & line_end_s & (row_r == (height_r - W_SIZE'(1)));
   assign add_red_s   = 32'(in_r0) + 32'(in_r1);
   assign add_grn_s   = 32'(in_g0) + 32'(in_g1);
   assign add_blu_s   = 32'(in_b0) + 32'(in_b1);
   assign unused_ok_s = ^{sl_HBURST, sl_HSIZE, sl_HADDR, sl_HWDATA};

   // Capture state register
   always_ff @(posedge HCLK) begin
      if (HRESET) state_r <= ST_IDLE;
      else        state_r <= state_n;
   end

   // Next-state logic; losing enable always returns to IDLE
   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_IDLE: begin
            if (en_r) state_n = ST_WAIT;
            else      state_n = ST_IDLE;
         end
         ST_WAIT: begin
            if (!en_r)           state_n = ST_IDLE;
            else if (in_valid)   state_n = frame_end_s ? ST_WAIT : ST_CAPT;
            else                 state_n = ST_WAIT;
         end
         ST_CAPT: begin
            if (!en_r)            state_n = ST_IDLE;
            else if (frame_end_s) state_n = ST_WAIT;
            else                  state_n = ST_CAPT;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Read mux, driven from the select latched in the address phase
   always_comb begin
      rd_s = 32'd0;
      case (sel_r)
         4'd0:    rd_s = 32'(width_r);
         4'd1:    rd_s = 32'(height_r);
         4'd2:    rd_s = {30'd0, irq_en_r, en_r};
         4'd3:    rd_s = {29'd0, overrun_r, done_r, (state_r == ST_CAPT)};
         4'd4:    rd_s = frame_cnt_r;
         4'd5:    rd_s = sum_red_r;
         4'd6:    rd_s = sum_grn_r;
         4'd7:    rd_s = sum_blu_r;
         4'd8:    rd_s = 32'(row_r);
         default: rd_s = 32'd0;
      endcase
   end
   assign out_sl_HRDATA = W_DATA'(rd_s);

   // Bus pipeline, register file, status flags and capture datapath
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         sel_r       <= 4'd0;
         we_r        <= 1'b0;
         width_r     <= W_SIZE'(768);
         height_r    <= W_SIZE'(512);
         en_r        <= 1'b0;
         irq_en_r    <= 1'b0;
         done_r      <= 1'b0;
         overrun_r   <= 1'b0;
         frame_cnt_r <= 32'd0;
         sum_red_r   <= 32'd0;
         sum_grn_r   <= 32'd0;
         sum_blu_r   <= 32'd0;
         acc_red_r   <= 32'd0;
         acc_grn_r   <= 32'd0;
         acc_blu_r   <= 32'd0;
         row_r       <= W_SIZE'(0);
         col_r       <= W_SIZE'(0);
      end else begin
         if (addr_ok_s) begin
            sel_r <= sl_HADDR[W_WB_DATA+3:W_WB_DATA];
            we_r  <= sl_HWRITE;
         end else begin
            we_r  <= 1'b0;
         end

         if (wr_s && (sel_r == 4'd0) && (state_r == ST_IDLE)) width_r  <= sl_HWDATA[W_SIZE-1:0];
         if (wr_s && (sel_r == 4'd1) && (state_r == ST_IDLE)) height_r <= sl_HWDATA[W_SIZE-1:0];
         if (wr_s && (sel_r == 4'd2)) begin
            en_r     <= sl_HWDATA[0];
            irq_en_r <= sl_HWDATA[1];
         end

         // A frame completion outranks a same-cycle W1C clear
         if (frame_end_s)     done_r <= 1'b1;
         else if (w1c_done_s) done_r <= 1'b0;
         if (frame_end_s && done_r) overrun_r <= 1'b1;
         else if (w1c_ovr_s)        overrun_r <= 1'b0;

         if (!en_r) begin
            acc_red_r <= 32'd0;
            acc_grn_r <= 32'd0;
            acc_blu_r <= 32'd0;
            row_r     <= W_SIZE'(0);
            col_r     <= W_SIZE'(0);
         end else if (frame_end_s) begin
            sum_red_r   <= acc_red_r + add_red_s;
            sum_grn_r   <= acc_grn_r + add_grn_s;
            sum_blu_r   <= acc_blu_r + add_blu_s;
            frame_cnt_r <= frame_cnt_r + 32'd1;
            acc_red_r   <= 32'd0;
            acc_grn_r   <= 32'd0;
            acc_blu_r   <= 32'd0;
            row_r       <= W_SIZE'(0);
            col_r       <= W_SIZE'(0);
         end else if (beat_s) begin
            acc_red_r <= acc_red_r + add_red_s;
            acc_grn_r <= acc_grn_r + add_grn_s;
            acc_blu_r <= acc_blu_r + add_blu_s;
            if (line_end_s) begin
               col_r <= W_SIZE'(0);
               row_r <= row_r + W_SIZE'(1);
            end else begin
               col_r <= col_r + W_SIZE'(2);
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_capture_if.sv
// Directed bench for lcd_capture_if: a beat-count frame model checked every cycle,
// plus literal register readbacks for each scenario.
module tb_lcd_capture_if;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        sl_HREADY, sl_HSEL, sl_HWRITE;
   logic [1:0]  sl_HTRANS;
   logic [2:0]  sl_HBURST, sl_HSIZE;
   logic [31:0] sl_HADDR, sl_HWDATA;
   logic        out_sl_HREADY;
   logic [1:0]  out_sl_HRESP;
   logic [31:0] out_sl_HRDATA;
   logic        in_valid;
   logic [7:0]  in_r0, in_g0, in_b0, in_r1, in_g1, in_b1;
   logic        out_irq;

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   lcd_capture_if dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .sl_HREADY(sl_HREADY), .sl_HSEL(sl_HSEL), .sl_HTRANS(sl_HTRANS),
      .sl_HBURST(sl_HBURST), .sl_HSIZE(sl_HSIZE), .sl_HADDR(sl_HADDR),
      .sl_HWRITE(sl_HWRITE), .sl_HWDATA(sl_HWDATA),
      .out_sl_HREADY(out_sl_HREADY), .out_sl_HRESP(out_sl_HRESP),
      .out_sl_HRDATA(out_sl_HRDATA),
      .in_valid(in_valid),
      .in_r0(in_r0), .in_g0(in_g0), .in_b0(in_b0),
      .in_r1(in_r1), .in_g1(in_g1), .in_b1(in_b1),
      .out_irq(out_irq)
   );

   always #5 HCLK = ~HCLK;

   // Frame model: a frame is WIDTH/2*HEIGHT accepted beats once armed
   logic [3:0]  m_sel;
   logic        m_we, m_en, m_irq_en, m_done, m_ov, m_armed;
   int unsigned m_width, m_height, m_frames, m_cnt;
   int unsigned m_sum_r, m_sum_g, m_sum_b, m_acc_r, m_acc_g, m_acc_b;

   function automatic logic [31:0] m_read(input logic [3:0] s);
      case (s)
         4'd0:    return m_width;
         4'd1:    return m_height;
         4'd2:    return {30'd0, m_irq_en, m_en};
         4'd3:    return {29'd0, m_ov, m_done, (m_armed && m_cnt != 0)};
         4'd4:    return m_frames;
         4'd5:    return m_sum_r;
         4'd6:    return m_sum_g;
         4'd7:    return m_sum_b;
         4'd8:    return (m_width >= 2) ? m_cnt / (m_width / 2) : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge HCLK) begin : model_step
      int unsigned ar, ag, ab, cnt;
      logic dn, ov;
      if (HRESET) begin
         m_sel <= 4'd0; m_we <= 1'b0; m_en <= 1'b0; m_irq_en <= 1'b0;
         m_done <= 1'b0; m_ov <= 1'b0; m_armed <= 1'b0;
         m_width <= 768; m_height <= 512; m_frames <= 0; m_cnt <= 0;
         m_sum_r <= 0; m_sum_g <= 0; m_sum_b <= 0;
         m_acc_r <= 0; m_acc_g <= 0; m_acc_b <= 0;
      end else begin
         dn = m_done; ov = m_ov;
         ar = m_acc_r; ag = m_acc_g; ab = m_acc_b; cnt = m_cnt;
         if (m_we) begin
            case (m_sel)
               4'd0: if (!m_armed) m_width <= sl_HWDATA & 32'h0000_0fff;
               4'd1: if (!m_armed) m_height <= sl_HWDATA & 32'h0000_0fff;
               4'd2: begin m_en <= sl_HWDATA[0]; m_irq_en <= sl_HWDATA[1]; end
               4'd3: begin if (sl_HWDATA[1]) dn = 1'b0; if (sl_HWDATA[2]) ov = 1'b0; end
               default: ;
            endcase
         end
         if (!m_en) begin
            m_armed <= 1'b0; cnt = 0; ar = 0; ag = 0; ab = 0;
         end else if (!m_armed) begin
            m_armed <= 1'b1;
         end else if (in_valid) begin
            ar = ar + 32'(in_r0) + 32'(in_r1);
            ag = ag + 32'(in_g0) + 32'(in_g1);
            ab = ab + 32'(in_b0) + 32'(in_b1);
            cnt = cnt + 1;
            if (cnt == (m_width / 2) * m_height) begin
               m_sum_r <= ar; m_sum_g <= ag; m_sum_b <= ab;
               m_frames <= m_frames + 1;
               if (m_done) ov = 1'b1;
               dn = 1'b1;
               cnt = 0; ar = 0; ag = 0; ab = 0;
            end
         end
         m_cnt <= cnt; m_acc_r <= ar; m_acc_g <= ag; m_acc_b <= ab;
         m_done <= dn; m_ov <= ov;
         if (sl_HSEL && sl_HREADY && sl_HTRANS[1]) begin
            m_sel <= sl_HADDR[5:2];
            m_we  <= sl_HWRITE;
         end else begin
            m_we  <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge HCLK) begin
      if (chk_en) begin
         chk("model_rdata", out_sl_HRDATA, m_read(m_sel));
         chk("model_irq", 32'(out_irq), 32'(m_irq_en & m_done));
         chk("hready", 32'(out_sl_HREADY), 32'd1);
         chk("hresp", 32'(out_sl_HRESP), 32'd0);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge HCLK);
   endtask

   task automatic wr(input int off, input logic [31:0] d);
      @(negedge HCLK);
      sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b1; sl_HADDR = 32'(off) << 2;
      @(negedge HCLK);
      sl_HSEL = 1'b0; sl_HTRANS = 2'b00; sl_HWRITE = 1'b0; sl_HWDATA = d;
   endtask

   task automatic rd(input int off, input logic [31:0] exp, input string name);
      @(negedge HCLK);
      sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b0; sl_HADDR = 32'(off) << 2;
      @(negedge HCLK);
      sl_HSEL = 1'b0; sl_HTRANS = 2'b00;
      chk(name, out_sl_HRDATA, exp);
   endtask

   task automatic set_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      in_r0 = r; in_r1 = r; in_g0 = g; in_g1 = g; in_b0 = b; in_b1 = b;
   endtask

   task automatic beat(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      @(negedge HCLK);
      in_valid = 1'b1; set_pix(r, g, b);
      @(negedge HCLK);
      in_valid = 1'b0;
   endtask

   task automatic check_reset_regs(input string tag);
      logic [31:0] rv [9];
      rv = '{32'd768, 32'd512, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
      for (int i = 0; i < 9; i++) rd(i, rv[i], $sformatf("%s_off%0d", tag, i));
      chk({tag, "_irq"}, 32'(out_irq), 32'd0);
   endtask

   initial begin
      HRESET = 1'b1; sl_HREADY = 1'b1; sl_HSEL = 1'b0; sl_HWRITE = 1'b0;
      sl_HTRANS = 2'b00; sl_HBURST = 3'd0; sl_HSIZE = 3'd2;
      sl_HADDR = 32'd0; sl_HWDATA = 32'd0; in_valid = 1'b0;
      set_pix(8'd0, 8'd0, 8'd0);
      idle(3);
      HRESET = 1'b0;
      chk_en = 1'b1;
      check_reset_regs("reset");

      // First 4x2 frame with gaps between beats
      wr(0, 32'd4); wr(1, 32'd2); wr(2, 32'd3); idle(2);
      for (int i = 0; i < 4; i++) beat(8'd1, 8'd2, 8'd3);
      rd(5, 32'd8, "f1_sum_r"); rd(6, 32'd16, "f1_sum_g"); rd(7, 32'd24, "f1_sum_b");
      rd(4, 32'd1, "f1_frames"); rd(3, 32'd2, "f1_status");
      chk("f1_irq", 32'(out_irq), 32'd1);

      // Second frame while done still set
      for (int i = 0; i < 4; i++) beat(8'd1, 8'd2, 8'd3);
      rd(4, 32'd2, "f2_frames"); rd(3, 32'd6, "f2_status"); rd(5, 32'd8, "f2_sum_r");
      wr(3, 32'd6);
      rd(3, 32'd0, "w1c_status");
      chk("w1c_irq", 32'(out_irq), 32'd0);

      // Abort after 3 beats, then a full frame of red 255
      for (int i = 0; i < 3; i++) beat(8'd1, 8'd2, 8'd3);
      rd(8, 32'd1, "abort_row"); rd(3, 32'd1, "abort_busy");
      wr(2, 32'd2); idle(1);
      rd(3, 32'd0, "disabled_status"); rd(8, 32'd0, "disabled_row");
      wr(2, 32'd3); idle(2);
      for (int i = 0; i < 4; i++) beat(8'd255, 8'd0, 8'd0);
      rd(5, 32'd2040, "f3_sum_r"); rd(6, 32'd0, "f3_sum_g");
      rd(4, 32'd3, "f3_frames"); rd(3, 32'd2, "f3_status");

      // WIDTH is locked outside IDLE
      beat(8'd1, 8'd1, 8'd1);
      wr(0, 32'd8); rd(0, 32'd4, "width_locked");
      wr(2, 32'd0); wr(0, 32'd8); rd(0, 32'd8, "width_idle");

      // Final beat of a 4x1 frame coincides with a W1C clear of done/overrun
      wr(0, 32'd4); wr(1, 32'd1); wr(2, 32'd3); idle(2);
      beat(8'd5, 8'd5, 8'd5);
      @(negedge HCLK);
      sl_HSEL = 1'b1; sl_HTRANS = 2'b10; sl_HWRITE = 1'b1; sl_HADDR = 32'd12;
      @(negedge HCLK);
      sl_HSEL = 1'b0; sl_HTRANS = 2'b00; sl_HWRITE = 1'b0; sl_HWDATA = 32'd6;
      in_valid = 1'b1;
      @(negedge HCLK);
      in_valid = 1'b0;
      rd(3, 32'd6, "set_wins_status"); rd(4, 32'd4, "set_wins_frames");
      rd(5, 32'd20, "set_wins_sum_r");

      // Reset on the second beat of a frame
      wr(2, 32'd0); wr(0, 32'd8); wr(1, 32'd2); wr(2, 32'd3); idle(2);
      beat(8'd9, 8'd9, 8'd9);
      @(negedge HCLK);
      in_valid = 1'b1; HRESET = 1'b1;
      @(negedge HCLK);
      in_valid = 1'b0; HRESET = 1'b0;
      check_reset_regs("midreset");

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
